seq_div_16: RTL and testbench



---
 rtl/seq_div_16.sv | 123 ++++++++++++
 tb/tb_seq_div_16.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_16.sv
// seq_div_16: sequential signed 16-bit divider.
// Restoring division on operand magnitudes, one quotient bit per clock,
// followed by a sign-fix cycle. Quotient truncates toward zero and the
// remainder takes the dividend's sign. -32768 / -1 wraps to 16'h8000.
// Optional feature macro: SEQ_DIV_ZERO_DET_EN. When it is defined, a zero
// divisor skips the iteration and completes one cycle after accept with
// dz=1, Q=0 and R=X.
module seq_div_16 (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic signed [15:0] X,
   input  logic signed [15:0] Y,
   output logic signed [15:0] Q,
   output logic signed [15:0] R,
   output logic               busy,
   output logic               done,
   output logic               dz
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   logic [1:0]  state;
   logic        sx, sy;
   logic [15:0] a;      // dividend magnitude, shifted out MSB first
   logic [15:0] b;      // divisor magnitude
   logic [15:0] p;      // partial remainder
   logic [15:0] m;      // quotient magnitude
   logic [3:0]  cnt;
   logic [16:0] ax, by; // 17-bit magnitudes so that |-32768| = 32768
   logic [16:0] p_sh;
   logic        ge;

   // Operand magnitudes and the restoring trial compare for this iteration
   always_comb begin
      ax   = X[15] ? (17'd0 - {X[15], X}) : {1'b0, X};
      by   = Y[15] ? (17'd0 - {Y[15], Y}) : {1'b0, Y};
      p_sh = {p, a[15]};
      ge   = (p_sh >= {1'b0, b});
   end

   assign busy = (state != IDLE);

`ifdef SEQ_DIV_ZERO_DET_EN
   logic zflag;
   logic dz_r;
   assign dz = dz_r;
`else
   assign dz = 1'b0;
`endif

   // Control FSM, datapath iteration and registered results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sx    <= 1'b0;
         sy    <= 1'b0;
         a     <= '0;
         b     <= '0;
         p     <= '0;
         m     <= '0;
         cnt   <= '0;
         Q     <= '0;
         R     <= '0;
         done  <= 1'b0;
`ifdef SEQ_DIV_ZERO_DET_EN
         zflag <= 1'b0;
         dz_r  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sx  <= X[15];
                  sy  <= Y[15];
                  a   <= ax[15:0];
                  b   <= by[15:0];
                  p   <= '0;
                  m   <= '0;
                  cnt <= '0;
`ifdef SEQ_DIV_ZERO_DET_EN
                  // zero divisor bypasses the iteration entirely
                  zflag <= (Y == 16'sd0);
                  state <= (Y == 16'sd0) ? FIX : CALC;
`else
                  state <= CALC;
`endif
               end
            end
            CALC: begin
               a   <= {a[14:0], 1'b0};
               p   <= ge ? 16'(p_sh - {1'b0, b}) : p_sh[15:0];
               m   <= {m[14:0], ge};
               cnt <= cnt + 4'd1;
               if (cnt == 4'd15) state <= FIX;
            end
            FIX: begin
`ifdef SEQ_DIV_ZERO_DET_EN
               if (zflag) begin
                  // a still holds |X| because CALC was skipped
                  Q <= '0;
                  R <= sx ? (16'd0 - a) : a;
               end else begin
                  Q <= (sx ^ sy) ? (16'd0 - m) : m;
                  R <= sx ? (16'd0 - p) : p;
               end
               dz_r <= zflag;
`else
               Q <= (sx ^ sy) ? (16'd0 - m) : m;
               R <= sx ? (16'd0 - p) : p;
`endif
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div_16.sv
// Self-checking bench for seq_div_16: directed vector table, held-start and
// mid-operation reset sequences, and a randomized sweep against an
// arithmetic reference model. Honours SEQ_DIV_ZERO_DET_EN.
module tb_seq_div_16;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic signed [15:0] X = '0;
   logic signed [15:0] Y = '0;
   logic signed [15:0] Q, R;
   logic               busy, done, dz;

   int checks = 0;
   int errors = 0;

   seq_div_16 dut (
      .clk(clk), .rst_n(rst_n), .start(start), .X(X), .Y(Y),
      .Q(Q), .R(R), .busy(busy), .done(done), .dz(dz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] x, y, q, r;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t tv[9];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: truncating division from plain integer arithmetic.
   function automatic void model(input int x, input int y, output logic [15:0] q,
                                 output logic [15:0] r, output logic d, output int lat);
      if (y == 0) begin
`ifdef SEQ_DIV_ZERO_DET_EN
         q = 16'h0000; r = 16'(x); d = 1'b1; lat = 1;
`else
         q = (x < 0) ? 16'h0001 : 16'hFFFF; r = 16'(x); d = 1'b0; lat = 17;
`endif
      end else begin
         // 32768 truncates to 16'h8000: the -32768/-1 wrap rule
         q = 16'(x / y); r = 16'(x % y); d = 1'b0; lat = 17;
      end
   endfunction

   // Issue one operation; returns cycles from accept edge to visible done.
   task automatic run_op(input logic [15:0] x, input logic [15:0] y, output int lat);
      @(negedge clk);
      X = x; Y = y; start = 1'b1;
      @(posedge clk);
      lat = 0;
      @(negedge clk);
      start = 1'b0;
      // scramble inputs: captured operands must be unaffected
      X = 16'($urandom); Y = 16'($urandom);
      while (!done && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   initial begin
      int lat;
      logic [15:0] eq, er;
      logic ed;
      int el;

      tv[0] = '{16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17};
      tv[1] = '{-16'sd100, 16'd7, -16'sd14, -16'sd2, 1'b0, 17};
      tv[2] = '{16'd100, -16'sd7, -16'sd14, 16'd2, 1'b0, 17};
      tv[3] = '{-16'sd100, -16'sd7, 16'd14, -16'sd2, 1'b0, 17};
      tv[4] = '{16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 17};
      tv[5] = '{16'd7, 16'd100, 16'd0, 16'd7, 1'b0, 17};
      tv[6] = '{16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 17};
`ifdef SEQ_DIV_ZERO_DET_EN
      tv[7] = '{-16'sd300, 16'd0, 16'd0, -16'sd300, 1'b1, 1};
      tv[8] = '{16'd100, 16'd0, 16'd0, 16'd100, 1'b1, 1};
`else
      tv[7] = '{-16'sd300, 16'd0, 16'h0001, -16'sd300, 1'b0, 17};
      tv[8] = '{16'd100, 16'd0, 16'hFFFF, 16'd100, 1'b0, 17};
`endif

      // reset state
      #12;
      chk("rst_q", Q, 16'd0);
      chk("rst_r", R, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_done", {15'd0, done}, 16'd0);
      chk("rst_dz", {15'd0, dz}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_done", {15'd0, done}, 16'd0);

      // directed table
      for (int i = 0; i < 9; i++) begin
         run_op(tv[i].x, tv[i].y, lat);
         chk($sformatf("tv%0d_lat", i), 16'(lat), 16'(tv[i].lat));
         chk($sformatf("tv%0d_q", i), Q, tv[i].q);
         chk($sformatf("tv%0d_r", i), R, tv[i].r);
         chk($sformatf("tv%0d_dz", i), {15'd0, dz}, {15'd0, tv[i].dz});
         chk($sformatf("tv%0d_busy", i), {15'd0, busy}, 16'd0);
         @(negedge clk);
         chk($sformatf("tv%0d_pulse", i), {15'd0, done}, 16'd0);
      end

      // start held high; X changes mid-CALC, then back-to-back accept
      @(negedge clk);
      X = 16'sd50; Y = 16'sd5; start = 1'b1;
      @(posedge clk);
      lat = 0;
      @(negedge clk);
      chk("hold_busy", {15'd0, busy}, 16'd1);
      while (!done && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 5) X = 16'sd99;
      end
      chk("hold1_lat", 16'(lat), 16'd17);
      chk("hold1_q", Q, 16'd10);
      chk("hold1_r", R, 16'd0);
      @(posedge clk);
      lat = 0;
      @(negedge clk);
      start = 1'b0;
      while (!done && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk("hold2_lat", 16'(lat), 16'd17);
      chk("hold2_q", Q, 16'd19);
      chk("hold2_r", R, 16'd4);

      // asynchronous reset during CALC discards the operation
      @(negedge clk);
      X = 16'sd1234; Y = 16'sd11; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_q", Q, 16'd0);
      chk("arst_r", R, 16'd0);
      chk("arst_busy", {15'd0, busy}, 16'd0);
      chk("arst_dz", {15'd0, dz}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int seen = 0;
         repeat (25) begin
            @(negedge clk);
            if (done) seen++;
         end
         chk("arst_no_done", 16'(seen), 16'd0);
      end
      run_op(16'd1000, 16'd33, lat);
      chk("post_rst_lat", 16'(lat), 16'd17);
      chk("post_rst_q", Q, 16'd30);
      chk("post_rst_r", R, 16'd10);

      // randomized sweep with a reference model
      for (int n = 0; n < 2000; n++) begin
         logic [15:0] rx, ry;
         rx = 16'($urandom);
         case (n % 8)
            0: ry = 16'hFFFF;
            1: ry = 16'd1;
            2: ry = 16'($urandom_range(1, 15));
            default: ry = 16'($urandom);
         endcase
         if (n % 16 == 3) rx = 16'h8000;
         if (ry == 16'd0) ry = 16'd3;
         model(int'($signed(rx)), int'($signed(ry)), eq, er, ed, el);
         run_op(rx, ry, lat);
         chk($sformatf("rnd_q %h/%h", rx, ry), Q, eq);
         chk($sformatf("rnd_r %h/%h", rx, ry), R, er);
         if (n % 50 == 0) begin
            chk("rnd_lat", 16'(lat), 16'(el));
            chk("rnd_dz", {15'd0, dz}, {15'd0, ed});
         end
      end

      // zero divisor through the model, then dz clears on a normal divide
      model(-77, 0, eq, er, ed, el);
      run_op(-16'sd77, 16'd0, lat);
      chk("z_lat", 16'(lat), 16'(el));
      chk("z_q", Q, eq);
      chk("z_r", R, er);
      chk("z_dz", {15'd0, dz}, {15'd0, ed});
      run_op(16'd9, 16'd2, lat);
      chk("z_clear_dz", {15'd0, dz}, 16'd0);
      chk("z_clear_q", Q, 16'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
